tic_tac_toe_nxn: RTL and testbench

Clocked, parametrised N×N, K-in-a-row two-player board engine, the next generation of the 3×3 button-driven game. It accepts coordinate-addressed moves through a valid/ready handshake, rejects illegal moves, and alternates turns automatically. After each placement it runs a multi-cycle win scan through the placed cell only, then latches win, draw, or full status until reset. It sits between the input decoder (buttons or host) and the display/LED logic.

---
 rtl/tic_tac_toe_nxn_pkg.sv | 20 ++
 rtl/tic_tac_toe_nxn_line_run.sv | 61 ++++++
 rtl/tic_tac_toe_nxn.sv | 164 ++++++++++++++++
 tb/tb_tic_tac_toe_nxn.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tic_tac_toe_nxn_pkg.sv
// Shared types, direction encodings and cell indexing for the N x N, K-in-a-row board engine.
package ttt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StDone
  } state_e;

  localparam logic [1:0] DirH = 2'd0;
  localparam logic [1:0] DirV = 2'd1;
  localparam logic [1:0] DirD = 2'd2;
  localparam logic [1:0] DirA = 2'd3;

  function automatic int unsigned idx(input int unsigned row, input int unsigned col,
                                      input int unsigned n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/tic_tac_toe_nxn_line_run.sv
// Combinational run detector: does the line through (row, col) along dir hold K player stones?
module line_run
  import ttt_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned K  = 3,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic [N*N-1:0] occ,
  input  logic [CW-1:0]  row,
  input  logic [CW-1:0]  col,
  input  logic [1:0]     dir,
  output logic           hit
);

  int dr, dc, run, rf, cf, rb, cb;
  logic fwd, bwd;
  logic [N*N-1:0] sh_f, sh_b;

  always_comb begin
    dr   = 0;
    dc   = 1;
    run  = 1;
    fwd  = 1'b1;
    bwd  = 1'b1;
    rf   = 0;
    cf   = 0;
    rb   = 0;
    cb   = 0;
    sh_f = '0;
    sh_b = '0;
    unique case (dir)
      DirH: begin dr = 0; dc = 1;  end
      DirV: begin dr = 1; dc = 0;  end
      DirD: begin dr = 1; dc = 1;  end
      DirA: begin dr = 1; dc = -1; end
      default: ;
    endcase
    // K-1 steps each way is enough to decide run >= K, which also caps the run at 2K-1.
    for (int s = 1; s < int'(K); s++) begin
      rf   = int'(row) + s * dr;
      cf   = int'(col) + s * dc;
      rb   = int'(row) - s * dr;
      cb   = int'(col) - s * dc;
      sh_f = occ >> idx(rf, cf, N);
      sh_b = occ >> idx(rb, cb, N);
      if (fwd && rf >= 0 && rf < int'(N) && cf >= 0 && cf < int'(N) && sh_f[0]) begin
        run = run + 1;
      end else begin
        fwd = 1'b0;
      end
      if (bwd && rb >= 0 && rb < int'(N) && cb >= 0 && cb < int'(N) && sh_b[0]) begin
        run = run + 1;
      end else begin
        bwd = 1'b0;
      end
    end
    hit = run >= int'(K);
  end

endmodule

// File: rtl/tic_tac_toe_nxn.sv
// N x N, K-in-a-row two-player board engine: handshaked moves, legality check,
// four-cycle win scan through the placed cell, sticky win/draw status.
module tic_tac_toe_nxn
  import ttt_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned K  = 3,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           move_valid,
  input  logic [CW-1:0]  move_row,
  input  logic [CW-1:0]  move_col,
  output logic           move_ready,
  output logic           move_accept,
  output logic           move_reject,
  output logic [N*N-1:0] cell_p1,
  output logic [N*N-1:0] cell_p2,
  output logic           p1_turn,
  output logic           p2_turn,
  output logic           p1_win,
  output logic           p2_win,
  output logic           grid_full,
  output logic           draw
);

  localparam int unsigned Cells = N * N;
  localparam int unsigned CntW  = $clog2(Cells + 1);

  state_e           state_q, state_d;
  logic [Cells-1:0] cell_p1_q, cell_p1_d, cell_p2_q, cell_p2_d;
  logic             turn_q, turn_d;  // 0: player 1 to move
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic [CW-1:0]    row_q, row_d, col_q, col_d;
  logic             win_hit_q, win_hit_d;
  logic             p1_win_q, p1_win_d, p2_win_q, p2_win_d;
  logic             draw_q, draw_d;
  logic             accept_q, accept_d, reject_q, reject_d;

  logic [Cells-1:0] place_bit, line_occ;
  logic             in_range, occupied, full, hit;

  assign full      = cnt_q == CntW'(Cells);
  assign line_occ  = turn_q ? cell_p2_q : cell_p1_q;
  assign in_range  = (32'(move_row) < N) && (32'(move_col) < N);
  assign place_bit = in_range ? (Cells'(1) << idx(32'(move_row), 32'(move_col), N)) : '0;
  assign occupied  = |(place_bit & (cell_p1_q | cell_p2_q));

  line_run #(
    .N (N),
    .K (K),
    .CW(CW)
  ) u_line_run (
    .occ(line_occ),
    .row(row_q),
    .col(col_q),
    .dir(dir_q),
    .hit(hit)
  );

  always_comb begin
    state_d   = state_q;
    cell_p1_d = cell_p1_q;
    cell_p2_d = cell_p2_q;
    turn_d    = turn_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    row_d     = row_q;
    col_d     = col_q;
    win_hit_d = win_hit_q;
    p1_win_d  = p1_win_q;
    p2_win_d  = p2_win_q;
    draw_d    = draw_q;
    accept_d  = 1'b0;
    reject_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (move_valid) begin
          if (!in_range || occupied) begin
            reject_d = 1'b1;
          end else begin
            accept_d = 1'b1;
            if (turn_q) cell_p2_d = cell_p2_q | place_bit;
            else        cell_p1_d = cell_p1_q | place_bit;
            cnt_d     = cnt_q + CntW'(1);
            row_d     = move_row;
            col_d     = move_col;
            dir_d     = DirH;
            win_hit_d = 1'b0;
            state_d   = StCheck;
          end
        end
      end
      StCheck: begin
        win_hit_d = win_hit_q | hit;
        dir_d     = dir_q + 2'd1;
        if (dir_q == DirA) begin
          if (win_hit_q | hit) begin
            state_d = StDone;
            if (turn_q) p2_win_d = 1'b1;
            else        p1_win_d = 1'b1;
          end else if (full) begin
            state_d = StDone;
            draw_d  = 1'b1;
          end else begin
            turn_d  = ~turn_q;
            state_d = StIdle;
          end
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cell_p1_q <= '0;
      cell_p2_q <= '0;
      turn_q    <= 1'b0;
      cnt_q     <= '0;
      dir_q     <= DirH;
      row_q     <= '0;
      col_q     <= '0;
      win_hit_q <= 1'b0;
      p1_win_q  <= 1'b0;
      p2_win_q  <= 1'b0;
      draw_q    <= 1'b0;
      accept_q  <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cell_p1_q <= cell_p1_d;
      cell_p2_q <= cell_p2_d;
      turn_q    <= turn_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      row_q     <= row_d;
      col_q     <= col_d;
      win_hit_q <= win_hit_d;
      p1_win_q  <= p1_win_d;
      p2_win_q  <= p2_win_d;
      draw_q    <= draw_d;
      accept_q  <= accept_d;
      reject_q  <= reject_d;
    end
  end

  assign move_ready  = state_q == StIdle;
  assign move_accept = accept_q;
  assign move_reject = reject_q;
  assign cell_p1     = cell_p1_q;
  assign cell_p2     = cell_p2_q;
  assign p1_turn     = (state_q != StDone) & ~turn_q;
  assign p2_turn     = (state_q != StDone) & turn_q;
  assign p1_win      = p1_win_q;
  assign p2_win      = p2_win_q;
  assign grid_full   = full;
  assign draw        = draw_q;

endmodule

// File: tb/tb_tic_tac_toe_nxn.sv
// Bench for tic_tac_toe_nxn: directed games plus random games on 3x3/K3 and 5x5/K4 boards,
// checked against a whole-board reference model.
module tb_tic_tac_toe_nxn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, valid, sel;
  logic [2:0] row, col;

  logic       u3_ready, u3_acc, u3_rej, u3_p1t, u3_p2t, u3_w1, u3_w2, u3_full, u3_draw;
  logic [8:0] u3_c1, u3_c2;
  logic       u5_ready, u5_acc, u5_rej, u5_p1t, u5_p2t, u5_w1, u5_w2, u5_full, u5_draw;
  logic [24:0] u5_c1, u5_c2;

  tic_tac_toe_nxn #(.N(3), .K(3)) u3 (
    .clk(clk), .reset(reset), .move_valid(valid & ~sel), .move_row(row[1:0]),
    .move_col(col[1:0]), .move_ready(u3_ready), .move_accept(u3_acc), .move_reject(u3_rej),
    .cell_p1(u3_c1), .cell_p2(u3_c2), .p1_turn(u3_p1t), .p2_turn(u3_p2t), .p1_win(u3_w1),
    .p2_win(u3_w2), .grid_full(u3_full), .draw(u3_draw)
  );

  tic_tac_toe_nxn #(.N(5), .K(4)) u5 (
    .clk(clk), .reset(reset), .move_valid(valid & sel), .move_row(row), .move_col(col),
    .move_ready(u5_ready), .move_accept(u5_acc), .move_reject(u5_rej), .cell_p1(u5_c1),
    .cell_p2(u5_c2), .p1_turn(u5_p1t), .p2_turn(u5_p2t), .p1_win(u5_w1), .p2_win(u5_w2),
    .grid_full(u5_full), .draw(u5_draw)
  );

  // Views of whichever instance is selected
  logic        v_ready, v_acc, v_rej, v_p1t, v_p2t, v_w1, v_w2, v_full, v_draw;
  logic [63:0] v_c1, v_c2;
  assign v_ready = sel ? u5_ready : u3_ready;
  assign v_acc   = sel ? u5_acc   : u3_acc;
  assign v_rej   = sel ? u5_rej   : u3_rej;
  assign v_p1t   = sel ? u5_p1t   : u3_p1t;
  assign v_p2t   = sel ? u5_p2t   : u3_p2t;
  assign v_w1    = sel ? u5_w1    : u3_w1;
  assign v_w2    = sel ? u5_w2    : u3_w2;
  assign v_full  = sel ? u5_full  : u3_full;
  assign v_draw  = sel ? u5_draw  : u3_draw;
  assign v_c1    = sel ? 64'(u5_c1) : 64'(u3_c1);
  assign v_c2    = sel ? 64'(u5_c2) : 64'(u3_c2);

  int checks = 0;
  int errors = 0;

  // Reference model: board of 0 (empty) / 1 / 2, win decided by scanning every line.
  int mn, mk, m_turn, m_cnt;
  int bd[8][8];
  bit m_done, m_w1, m_w2;

  function automatic bit m_won(input int p);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    for (int r = 0; r < mn; r++)
      for (int c = 0; c < mn; c++)
        for (int d = 0; d < 4; d++) begin
          bit ok = 1'b1;
          for (int s = 0; s < mk; s++) begin
            int rr = r + s * dr[d];
            int cc = c + s * dc[d];
            if (rr < 0 || rr >= mn || cc < 0 || cc >= mn) ok = 1'b0;
            else if (bd[rr][cc] != p) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic m_reset(input int n, input int k);
    mn = n; mk = k; m_turn = 1; m_cnt = 0;
    m_done = 1'b0; m_w1 = 1'b0; m_w2 = 1'b0;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) bd[r][c] = 0;
  endtask

  function automatic bit m_legal(input int r, input int c);
    if (r >= mn || c >= mn) return 1'b0;
    return bd[r][c] == 0;
  endfunction

  task automatic m_apply(input int r, input int c);
    bd[r][c] = m_turn;
    m_cnt++;
    if (m_won(m_turn)) begin
      if (m_turn == 1) m_w1 = 1'b1;
      else m_w2 = 1'b1;
      m_done = 1'b1;
    end else if (m_cnt == mn * mn) begin
      m_done = 1'b1;
    end else begin
      m_turn = 3 - m_turn;
    end
  endtask

  function automatic logic [63:0] m_vec(input int p);
    logic [63:0] v = '0;
    for (int r = 0; r < mn; r++)
      for (int c = 0; c < mn; c++)
        if (bd[r][c] == p) v[r * mn + c] = 1'b1;
    return v;
  endfunction

  function automatic logic [6:0] m_status();
    // {p1_win, p2_win, grid_full, draw, p1_turn, p2_turn, move_ready}
    return {m_w1, m_w2, m_cnt == mn * mn, m_done && !m_w1 && !m_w2,
            !m_done && m_turn == 1, !m_done && m_turn == 2, !m_done};
  endfunction

  task automatic do_reset(input logic s, input int n, input int k);
    @(negedge clk);
    sel = s; reset = 1'b1; valid = 1'b0; row = '0; col = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    m_reset(n, k);
  endtask

  // Drives one move; returns in cycle t+1 if not accepted, else in cycle t+5.
  task automatic step(input int r, input int c, output logic a, output logic j,
                      output logic rdy1);
    @(negedge clk);
    valid = 1'b1; row = 3'(r); col = 3'(c);
    @(posedge clk);
    #1;
    a = v_acc; j = v_rej; rdy1 = v_ready;
    valid = 1'b0;
    if (a) begin
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0, 3, 3);
    checks++;
    if ({u3_ready, u3_acc, u3_rej, u3_p1t, u3_p2t, u3_w1, u3_w2, u3_full, u3_draw}
        !== 9'b100100000) begin
      errors++;
      $display("FAIL reset_flags_n3: got %b want 100100000",
               {u3_ready, u3_acc, u3_rej, u3_p1t, u3_p2t, u3_w1, u3_w2, u3_full, u3_draw});
    end
    checks++;
    if ((u3_c1 | u3_c2) !== 9'd0) begin
      errors++;
      $display("FAIL reset_cells_n3: got %h/%h want 0", u3_c1, u3_c2);
    end
    checks++;
    if ({u5_ready, u5_acc, u5_rej, u5_p1t, u5_p2t, u5_w1, u5_w2, u5_full, u5_draw}
        !== 9'b100100000) begin
      errors++;
      $display("FAIL reset_flags_n5: got %b want 100100000",
               {u5_ready, u5_acc, u5_rej, u5_p1t, u5_p2t, u5_w1, u5_w2, u5_full, u5_draw});
    end
    checks++;
    if ((u5_c1 | u5_c2) !== 25'd0) begin
      errors++;
      $display("FAIL reset_cells_n5: got %h/%h want 0", u5_c1, u5_c2);
    end
  endtask

  task automatic test_row_win();
    int rs[4] = '{0, 1, 0, 1};
    int cs[4] = '{0, 0, 1, 1};
    logic a, j, rd;
    do_reset(1'b0, 3, 3);
    for (int i = 0; i < 4; i++) begin
      step(rs[i], cs[i], a, j, rd);
      m_apply(rs[i], cs[i]);
      checks++;
      if (a !== 1'b1) begin
        errors++;
        $display("FAIL row_win_accept%0d: got %b want 1", i, a);
      end
    end
    // Final move (0,2), stepped by hand to check the t+5 latency.
    @(negedge clk);
    valid = 1'b1; row = 3'd0; col = 3'd2;
    @(posedge clk);
    #1 valid = 1'b0;
    m_apply(0, 2);
    checks++;
    if ({v_acc, v_ready} !== 2'b10) begin
      errors++;
      $display("FAIL row_win_t1: acc/ready got %b want 10", {v_acc, v_ready});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({v_w1, v_ready} !== 2'b00) begin
      errors++;
      $display("FAIL row_win_t4: win/ready got %b want 00", {v_w1, v_ready});
    end
    @(posedge clk);
    #1;
    checks++;
    if (v_status_now() !== m_status()) begin
      errors++;
      $display("FAIL row_win_t5: status got %b want %b", v_status_now(), m_status());
    end
    checks++;
    if (u3_c1 !== 9'b000000111) begin
      errors++;
      $display("FAIL row_win_cells: cell_p1 got %b want 000000111", u3_c1);
    end
    // DONE ignores further requests.
    @(negedge clk);
    valid = 1'b1; row = 3'd2; col = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({v_acc, v_rej, v_c1, v_c2} !== {2'b00, m_vec(1), m_vec(2)}) begin
      errors++;
      $display("FAIL done_ignore: acc/rej %b%b cells %h/%h want 00 %h/%h", v_acc, v_rej,
               v_c1, v_c2, m_vec(1), m_vec(2));
    end
    valid = 1'b0;
  endtask

  function automatic logic [6:0] v_status_now();
    return {v_w1, v_w2, v_full, v_draw, v_p1t, v_p2t, v_ready};
  endfunction

  task automatic test_reject();
    logic a, j, rd;
    do_reset(1'b0, 3, 3);
    step(1, 1, a, j, rd);
    m_apply(1, 1);
    step(1, 1, a, j, rd);
    checks++;
    if ({a, j, rd} !== 3'b011) begin
      errors++;
      $display("FAIL reject_occupied: acc/rej/ready got %b want 011", {a, j, rd});
    end
    checks++;
    if ({v_c1, v_c2, v_p1t, v_p2t} !== {m_vec(1), m_vec(2), 2'b01}) begin
      errors++;
      $display("FAIL reject_state: cells %h/%h turns %b%b want %h/%h 01", v_c1, v_c2, v_p1t,
               v_p2t, m_vec(1), m_vec(2));
    end
    step(3, 0, a, j, rd);
    checks++;
    if ({a, j} !== 2'b01) begin
      errors++;
      $display("FAIL reject_row_range: acc/rej got %b want 01", {a, j});
    end
    step(0, 3, a, j, rd);
    checks++;
    if ({a, j} !== 2'b01) begin
      errors++;
      $display("FAIL reject_col_range: acc/rej got %b want 01", {a, j});
    end
    step(2, 2, a, j, rd);
    m_apply(2, 2);
    checks++;
    if ({a, v_c2, v_status_now()} !== {1'b1, m_vec(2), m_status()}) begin
      errors++;
      $display("FAIL reject_then_play: acc %b p2 %h status %b want 1 %h %b", a, v_c2,
               v_status_now(), m_vec(2), m_status());
    end
  endtask

  task automatic play_table(input logic s, input int n, input int k, input int cnt,
                            input int rs[9], input int cs[9], input string tag);
    logic a, j, rd;
    do_reset(s, n, k);
    for (int i = 0; i < cnt; i++) begin
      step(rs[i], cs[i], a, j, rd);
      m_apply(rs[i], cs[i]);
    end
    checks++;
    if ({v_c1, v_c2, v_status_now()} !== {m_vec(1), m_vec(2), m_status()}) begin
      errors++;
      $display("FAIL %s: cells %h/%h status %b want %h/%h %b", tag, v_c1, v_c2,
               v_status_now(), m_vec(1), m_vec(2), m_status());
    end
  endtask

  task automatic test_draw();
    play_table(1'b0, 3, 3, 9, '{0, 0, 0, 1, 1, 1, 2, 2, 2}, '{0, 1, 2, 1, 0, 2, 1, 0, 2},
               "draw_model");
    checks++;
    if (v_status_now() !== 7'b0011000) begin
      errors++;
      $display("FAIL draw_flags: got %b want 0011000", v_status_now());
    end
  endtask

  task automatic test_antidiag_final();
    play_table(1'b0, 3, 3, 9, '{1, 0, 0, 0, 1, 1, 2, 2, 2}, '{1, 0, 2, 1, 0, 2, 2, 1, 0},
               "antidiag_model");
    checks++;
    if (v_status_now() !== 7'b1010000) begin
      errors++;
      $display("FAIL antidiag_flags: got %b want 1010000", v_status_now());
    end
  endtask

  task automatic test_vertical_n5();
    play_table(1'b1, 5, 4, 6, '{0, 1, 2, 2, 4, 3, 0, 0, 0}, '{0, 3, 1, 3, 0, 3, 0, 0, 0},
               "n5_three_run");
    checks++;
    if ({v_w1, v_w2, v_p1t, v_ready} !== 4'b0011) begin
      errors++;
      $display("FAIL n5_no_win_at_3: w1/w2/p1t/ready got %b want 0011",
               {v_w1, v_w2, v_p1t, v_ready});
    end
    play_table(1'b1, 5, 4, 8, '{0, 1, 2, 2, 4, 3, 0, 4, 0}, '{0, 3, 1, 3, 0, 3, 4, 3, 0},
               "n5_four_run");
    checks++;
    if ({v_w1, v_w2, v_full, v_ready, u5_c2} !== {4'b0100, 25'h0842100}) begin
      errors++;
      $display("FAIL n5_win_at_4: flags %b p2 %h want 0100 0842100",
               {v_w1, v_w2, v_full, v_ready}, u5_c2);
    end
  endtask

  task automatic test_reset_mid_check();
    logic a, j, rd;
    int rs[4] = '{0, 1, 0, 1};
    int cs[4] = '{0, 0, 1, 1};
    do_reset(1'b0, 3, 3);
    for (int i = 0; i < 4; i++) step(rs[i], cs[i], a, j, rd);
    @(negedge clk);
    valid = 1'b1; row = 3'd0; col = 3'd2;
    @(posedge clk);
    #1 valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_reset(3, 3);
    checks++;
    if ({u3_c1, u3_c2, v_status_now()} !== {18'd0, 7'b0000101}) begin
      errors++;
      $display("FAIL mid_check_reset: cells %h/%h status %b want 0/0 0000101", u3_c1, u3_c2,
               v_status_now());
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({v_w1, v_w2, v_ready} !== 3'b001) begin
      errors++;
      $display("FAIL mid_check_no_win: w1/w2/ready got %b want 001", {v_w1, v_w2, v_ready});
    end
  endtask

  task automatic test_random_games();
    logic a, j, rd;
    for (int g = 0; g < 8; g++) begin
      logic s = g[0];
      int n = s ? 5 : 3;
      do_reset(s, n, s ? 4 : 3);
      for (int t = 0; t < 120 && !m_done; t++) begin
        int r = $urandom_range(0, s ? 7 : 3);
        int c = $urandom_range(0, s ? 7 : 3);
        bit lg = m_legal(r, c);
        step(r, c, a, j, rd);
        if (lg) m_apply(r, c);
        checks++;
        if ({a, j} !== {lg, !lg}) begin
          errors++;
          $display("FAIL rand_handshake g%0d (%0d,%0d): acc/rej %b%b want %b%b", g, r, c, a,
                   j, lg, !lg);
        end
        checks++;
        if ({v_c1, v_c2, v_status_now()} !== {m_vec(1), m_vec(2), m_status()}) begin
          errors++;
          $display("FAIL rand_state g%0d (%0d,%0d): cells %h/%h status %b want %h/%h %b", g, r,
                   c, v_c1, v_c2, v_status_now(), m_vec(1), m_vec(2), m_status());
        end
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time %0t want finish before limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; valid = 1'b0; sel = 1'b0; row = '0; col = '0;
    test_reset();
    test_row_win();
    test_reject();
    test_draw();
    test_antidiag_final();
    test_vertical_n5();
    test_reset_mid_check();
    test_random_games();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
